// File: rtl/wam_hit.sv
// wam_hit: whack-a-mole hit detector that synchronises, optionally debounces and edge-detects eight hole buttons.
// Each press edge is qualified against the mole vector.
// Optional feature macro: WAM_HIT_DEBOUNCE_EN. When it is defined, per-button debounce counters are built.
// When it is undefined, btn_db is the synchronised button level.
// Ports:
//   clk    - system clock, all state on rising edge
//   clr_n  - synchronous active-low reset
//   btn    - raw asynchronous active-high hole buttons
//   mole   - current mole-up vector, synchronous to clk
//   hit    - registered one-cycle pulse per hole on a qualified press
//   miss   - registered one-cycle pulse when any press edge is unqualified
//   btn_db - debounced button level
module wam_hit #(
    parameter int DB_W   = 4,
    parameter int DB_CNT = 15
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] btn,
    input  logic [7:0] mole,
    output logic [7:0] hit,
    output logic       miss,
    output logic [7:0] btn_db
);
    logic [7:0] r_s1, r_s2, r_db_q, r_mole_q, r_armed, r_hit;
    logic       r_miss;
    logic [7:0] w_db, w_pe, w_elig;

    if (DB_CNT < 1 || DB_CNT > (1 << DB_W) - 1) begin : g_bad_cfg
        $error("wam_hit: DB_CNT out of range for DB_W");
    end

`ifdef WAM_HIT_DEBOUNCE_EN
    logic [7:0]      r_db;
    logic [DB_W-1:0] r_c [8];

    // A bit's level is accepted only after DB_CNT consecutive cycles that disagree with it.
    // Any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_db <= '0;
            for (int i = 0; i < 8; i++) r_c[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_c[i] <= '0;
                end else if (r_c[i] == DB_W'(DB_CNT - 1)) begin
                    r_db[i] <= r_s2[i];
                    r_c[i]  <= '0;
                end else begin
                    r_c[i] <= r_c[i] + 1'b1;
                end
            end
        end
    end

    assign w_db = r_db;
`else
    assign w_db = r_s2;
`endif

    assign w_pe = w_db & ~r_db_q;
    // A mole that was already up last cycle is eligible only while still armed.
    // A freshly risen mole is always eligible.
    assign w_elig = mole & (r_armed | ~r_mole_q);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_db_q   <= '0;
            r_mole_q <= '0;
            r_armed  <= '0;
            r_hit    <= '0;
            r_miss   <= 1'b0;
        end else begin
            r_s1     <= btn;
            r_s2     <= r_s1;
            r_db_q   <= w_db;
            r_mole_q <= mole;
            r_armed  <= w_elig & ~w_pe;
            r_hit    <= w_pe & w_elig;
            r_miss   <= |(w_pe & ~w_elig);
        end
    end

    assign hit    = r_hit;
    assign miss   = r_miss;
    assign btn_db = w_db;
endmodule

// File: tb/tb_wam_hit.sv
// tb_wam_hit: scoreboard bench for wam_hit that compares it against an appearance/scored reference model.
// The bench also runs directed latency and counting checks.
module tb_wam_hit;
    localparam int DB = 15;
`ifdef WAM_HIT_DEBOUNCE_EN
    localparam bit DBE = 1'b1;
    localparam int LAT = 3 + DB;
`else
    localparam bit DBE = 1'b0;
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] btn = '0;
    logic [7:0] mole = '0;
    logic [7:0] hit;
    logic       miss;
    logic [7:0] btn_db;

    always #5 clk = ~clk;

    wam_hit #(.DB_W(4), .DB_CNT(DB)) dut (
        .clk(clk), .clr_n(clr_n), .btn(btn), .mole(mole),
        .hit(hit), .miss(miss), .btn_db(btn_db)
    );

    typedef struct packed {
        logic [7:0] hit;
        logic       miss;
        logic [7:0] db;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    // Reference model state: the button samples from one and two edges back, and the accepted level.
    // It also keeps each differing bit's run length, the last accepted level, and one flag per hole.
    // That flag records whether the current mole appearance has already been scored.
    logic [7:0] m_p1 = '0, m_p2 = '0, m_db = '0, m_db_q = '0, m_scored = '0;
    int         m_run [8];

    task automatic model_step();
        exp_t       e;
        logic [7:0] cur, pe, elig, h;
        if (!clr_n) begin
            m_p1 = '0; m_p2 = '0; m_db = '0; m_db_q = '0; m_scored = '0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            e = '0;
        end else begin
            cur  = DBE ? m_db : m_p2;
            pe   = cur & ~m_db_q;
            elig = mole & ~m_scored;
            h    = pe & elig;
            e.hit  = h;
            e.miss = |(pe & ~elig);
            for (int i = 0; i < 8; i++) begin
                m_scored[i] = mole[i] & (m_scored[i] | h[i]);
                if (m_p2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i]  = m_p2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_db_q = cur;
            m_p2   = m_p1;
            m_p1   = btn;
            e.db   = DBE ? m_db : m_p2;
        end
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Waits for the first nonzero hit and checks that it arrives exactly `need` edges after the call.
    task automatic wait_hit(input string name, input int need);
        int n = 0;
        do begin
            tick();
            n++;
        end while (hit == 8'h00 && n < 100);
        vectors++;
        if (hit == 8'h00 || n != need) begin
            errors++;
            $display("FAIL %s: hit=%h after %0d cycles, required nonzero after %0d", name, hit, n, need);
        end
    endtask

    task automatic check(input string name, input int got, input int need);
        vectors++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, need);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({hit, miss, btn_db} !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: hit=%h miss=%b btn_db=%h required hit=%h miss=%b btn_db=%h",
                         $time, hit, miss, btn_db, e.hit, e.miss, e.db);
            end
        end
    end

    initial begin
        int nh, nm, nc;
        logic [7:0] prev;
        ticks(3);
        clr_n = 1'b1;
        ticks(50);

        // Single press on a lit hole, held, released and pressed again.
        mole = 8'h04;
        btn  = 8'h04;
        wait_hit("first_press_latency", LAT);
        check("first_press_value", hit, 8'h04);
        nh = 0;
        for (int k = 0; k < 40; k++) begin tick(); nh += (hit != 0); end
        check("no_rehit_while_held", nh, 0);
        btn = 8'h00;
        ticks(40);
        btn = 8'h04;
        nh = 0; nm = 0;
        for (int k = 0; k < 40; k++) begin tick(); nh += (hit != 0); nm += miss; end
        check("second_press_hits", nh, 0);
        check("second_press_misses", nm, 1);

        // Bouncing button on a fresh mole appearance.
        btn = 8'h00; mole = 8'h00;
        ticks(40);
        mole = 8'h20;
        nh = 0; nc = 0; prev = btn_db;
        for (int k = 0; k < 8; k++) begin
            btn[5] = (k % 2 == 0);
            for (int j = 0; j < 5; j++) begin
                tick(); nh += hit[5]; nc += (btn_db[5] != prev[5]); prev = btn_db;
            end
        end
        btn[5] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(); nh += hit[5]; nc += (btn_db[5] != prev[5]); prev = btn_db;
        end
        check("bounce_hits", nh, 1);
        check("bounce_db_changes", nc, DBE ? 1 : 9);

        // Simultaneous hit and miss.
        btn = 8'h00; mole = 8'h00;
        ticks(40);
        mole = 8'h09; btn = 8'h0B;
        wait_hit("multi_latency", LAT);
        check("multi_hit", hit, 8'h09);
        check("multi_miss", miss, 1);

        // Reset in the middle of a debounce.
        btn = 8'h00; mole = 8'h00;
        ticks(40);
        mole = 8'h04; btn = 8'h04;
        ticks(12);
        clr_n = 1'b0;
        tick();
        check("reset_hit", hit, 0);
        check("reset_miss", miss, 0);
        check("reset_btn_db", btn_db, 0);
        clr_n = 1'b1;
        wait_hit("post_reset_latency", LAT);
        check("post_reset_value", hit, 8'h04);
        ticks(10);

        // Random stimulus with occasional resets and mole changes.
        for (int k = 0; k < 4000; k++) begin
            clr_n = ($urandom_range(599) != 0);
            if ($urandom_range(39) == 0) mole = 8'($urandom);
            if ($urandom_range(5) == 0) btn[$urandom_range(7)] ^= 1'b1;
            tick();
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/wam_hit.md
# wam_hit

Hit detector for the whack-a-mole game, sitting directly upstream of the score counter. It synchronises and debounces the eight raw hole buttons, detects press edges, and qualifies each press against the current mole vector. Qualified presses become one-cycle `hit[7:0]` pulses that feed the score counter; unqualified presses become `miss` pulses. Each mole appearance can be scored at most once.

## Interface
- `DB_W`, 4: debounce counter width.
- `DB_CNT`, 15: consecutive stable cycles required to accept a button change; range 1..2^DB_W-1.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `clr_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `btn` input 8: raw, asynchronous, active-high hole buttons.
- `mole` input 8: current mole-up vector from the mole generator; synchronous to `clk`.
- `hit` output 8: registered; one-cycle pulse per hole on a qualified press.
- `miss` output 1: registered; one-cycle pulse when any press edge is unqualified.
- `btn_db` output 8: debounced button level.

## Operation
- Synchroniser: two flops per bit (`s1` then `s2`).
- Debounce, per bit, with a `DB_W`-bit counter `c` and a stable level `btn_db`:
  - If `s2 == btn_db`: `c <= 0`.
  - Otherwise, if `c == DB_CNT-1`: `btn_db <= s2`, `c <= 0`.
  - Otherwise: `c <= c+1`.
  - A glitch shorter than `DB_CNT` cycles never changes `btn_db`.
- Press edge: `pe[i] = btn_db[i] & ~db_q[i]`, where `db_q` is `btn_db` delayed one cycle. Releases produce nothing.
- Mole tracking, with `mole_q` as `mole` delayed one cycle:
  - Eligibility: `elig[i] = mole[i] & (armed[i] | ~mole_q[i])`, so a press in the same cycle a mole rises is eligible.
  - Next armed state: `armed[i] <= mole[i] & (armed[i] | ~mole_q[i]) & ~(pe[i] & elig[i])`.
  - `armed[i]` clears when the mole drops or is hit, so one appearance gives at most one hit.
- Outputs:
  - `hit[i] <= pe[i] & elig[i]`.
  - `miss <= |(pe & ~elig)`.
- Simultaneous events:
  - Several holes may pulse `hit` in the same cycle. Each qualified bit is set, and the downstream OR counts them as one.
  - A hit and a miss in the same cycle on different holes both assert.
  - A press edge in the same cycle the mole drops (`mole[i]=0`) is a miss.
- Reset (`clr_n=0` at an edge) clears `s1`, `s2`, `c`, `btn_db`, `db_q`, `mole_q`, `armed`, `hit` and `miss` to 0. Reset mid-debounce discards the partial count.
- Behaviour after reset release:
  - A button held through reset is seen as a new press after debounce completes.
  - A mole high at reset release counts as a new appearance.

## Timing
- Button edge latency with debounce: `btn` stable high before edge E0 gives `btn_db` high at edge E(2+DB_CNT) and `hit`/`miss` at edge E(3+DB_CNT). With the default `DB_CNT`=15, `hit` appears at E18.
- Button edge latency without debounce: `hit`/`miss` at edge E3.
- `mole` to `hit` qualification: zero-latency. The values of `mole` and `mole_q` in the cycle where `pe` is high decide the outcome.
- Pulse widths: `hit` and `miss` are exactly one cycle wide per press edge. Two press edges on one hole need at least `2*DB_CNT` cycles between them (one release and one press debounce).
- Reset values: `hit`=0, `miss`=0, `btn_db`=0.

## Configuration
- `WAM_HIT_DEBOUNCE_EN` defined:
  - Debounce counters are present.
  - Latency is 3+`DB_CNT` cycles.
- Undefined:
  - No counters; `btn_db` = `s2` (combinational copy).
  - `DB_W` and `DB_CNT` are ignored.
  - Latency is 3 cycles.
  - Bounces pass through as multiple edges.

## Test plan
- Reset release, `mole`=0x00, `btn`=0x00 held 50 cycles -> `hit`=0x00, `miss`=0, `btn_db`=0x00 throughout.
- `mole`=0x04, `btn[2]` rises at E0 and is held (debounce on, `DB_CNT`=15) -> `hit`=0x04 for one cycle at E18, and no further `hit` while held.
- `mole`=0x04 held, `btn[2]` pressed, released and pressed again -> first press gives `hit`=0x04; second press gives `miss`=1 and `hit`=0x00 (already scored).
- `btn[5]` toggles with 5-cycle bounces for 40 cycles, then is held high, `mole`=0x20 -> exactly one `hit`=0x20, and `btn_db[5]` changes once.
- `mole`=0x09, `btn`=0x0B rises together -> `hit`=0x09 and `miss`=1 in the same cycle.
- Assert `clr_n`=0 at `c`=10 during a press -> all outputs 0. After release, with `btn` held, `hit` pulses 3+`DB_CNT` cycles after the release edge.
